arbitro_funcionalidade: RTL

Round-robin arbiter and sequencer for the 7-way functionality selector. It accepts up to seven concurrent function requests and grants exactly one at a time. While the grant is held, it drives the corresponding 3-bit function code to the datapath. The grant is held until the datapath acknowledges completion, the requester withdraws, or a timeout expires.

---
 rtl/arbitro_funcionalidade_if.sv | 30 +++
 rtl/arbitro_funcionalidade.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/arbitro_funcionalidade_if.sv
// Request/grant bus between the functionality requesters, the arbiter and the datapath.
interface arbitro_funcionalidade_if;
  logic [6:0] req;
  logic       func_done;
  logic [6:0] grant;
  logic [2:0] func_code;
  logic       func_valid;
  logic       busy;
  logic       timeout_err;

  modport master (
    output req,
    output func_done,
    input  grant,
    input  func_code,
    input  func_valid,
    input  busy,
    input  timeout_err
  );

  modport slave (
    input  req,
    input  func_done,
    output grant,
    output func_code,
    output func_valid,
    output busy,
    output timeout_err
  );
endinterface

// File: rtl/arbitro_funcionalidade.sv
// Round-robin arbiter/sequencer for the 7-way functionality selector.
// One grant at a time; a grant ends on func_done, requester withdrawal or
// timeout, followed by a single RELEASE cycle so grants never run back to back.
module arbitro_funcionalidade #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  arbitro_funcionalidade_if.slave fbus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // Counter value seen on the last allowed ACTIVE cycle.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Fixed index -> function code map.
  function automatic logic [2:0] code_of(input logic [2:0] idx);
    logic [2:0] code;
    case (idx)
      3'd0:    code = 3'b100;
      3'd1:    code = 3'b010;
      3'd2:    code = 3'b110;
      3'd3:    code = 3'b001;
      3'd4:    code = 3'b101;
      3'd5:    code = 3'b011;
      3'd6:    code = 3'b111;
      default: code = 3'b000;
    endcase
    return code;
  endfunction

  state_t           state_r, state_s;
  logic [2:0]       ptr_r, ptr_s;
  logic [2:0]       idx_r, idx_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [6:0]       grant_r, grant_s;
  logic [2:0]       code_r, code_s;
  logic             valid_r, valid_s;
  logic             busy_r, busy_s;
  logic             terr_r, terr_s;

  logic [3:0]       cand_s;
  logic [2:0]       win_s;
  logic             found_s;

  // Round-robin search starting just after the last served index, modulo 7.
  always_comb begin
    cand_s  = 4'd0;
    win_s   = 3'd0;
    found_s = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      cand_s  = {1'b0, ptr_r} + 4'(i);
      cand_s  = (cand_s >= 4'd7) ? (cand_s - 4'd7) : cand_s;
      win_s   = (!found_s && fbus.req[cand_s[2:0]]) ? cand_s[2:0] : win_s;
      found_s = found_s | fbus.req[cand_s[2:0]];
    end
  end

  // Next-state and next-output logic of the IDLE/ACTIVE/RELEASE sequencer.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    idx_s   = idx_r;
    cnt_s   = cnt_r;
    grant_s = grant_r;
    code_s  = code_r;
    valid_s = valid_r;
    busy_s  = busy_r;
    terr_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_s = {CNT_W{1'b0}};
        if (found_s) begin
          state_s = ST_ACTIVE;
          idx_s   = win_s;
          grant_s = 7'd1 << win_s;
          code_s  = code_of(win_s);
          valid_s = 1'b1;
          busy_s  = 1'b1;
        end else begin
          grant_s = 7'd0;
          code_s  = 3'b000;
          valid_s = 1'b0;
          busy_s  = 1'b0;
        end
      end
      ST_ACTIVE: begin
        cnt_s = cnt_r + CNT_W'(1);
        // done beats withdrawal beats timeout; only a pure timeout flags an error
        if (fbus.func_done || !fbus.req[idx_r] || (cnt_r == TMO_LAST)) begin
          state_s = ST_RELEASE;
          ptr_s   = idx_r;
          grant_s = 7'd0;
          code_s  = 3'b000;
          valid_s = 1'b0;
          busy_s  = 1'b1;
          terr_s  = !fbus.func_done && fbus.req[idx_r];
        end else begin
          state_s = ST_ACTIVE;
        end
      end
      ST_RELEASE: begin
        state_s = ST_IDLE;
        cnt_s   = {CNT_W{1'b0}};
        grant_s = 7'd0;
        code_s  = 3'b000;
        valid_s = 1'b0;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CNT_W{1'b0}};
        grant_s = 7'd0;
        code_s  = 3'b000;
        valid_s = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and registered-output update with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      ptr_r   <= 3'd6;
      idx_r   <= 3'd0;
      cnt_r   <= {CNT_W{1'b0}};
      grant_r <= 7'd0;
      code_r  <= 3'b000;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      terr_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      idx_r   <= idx_s;
      cnt_r   <= cnt_s;
      grant_r <= grant_s;
      code_r  <= code_s;
      valid_r <= valid_s;
      busy_r  <= busy_s;
      terr_r  <= terr_s;
    end
  end

  assign fbus.grant       = grant_r;
  assign fbus.func_code   = code_r;
  assign fbus.func_valid  = valid_r;
  assign fbus.busy        = busy_r;
  assign fbus.timeout_err = terr_r;

endmodule
